// File: rtl/fifo_uart_tx_drain.sv
// FIFO read-domain consumer: pops one word per frame and serializes it as a UART
// frame (start, LSB-first data, optional parity, stop) with a programmable bit period.
module fifo_uart_tx_drain #(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 8
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  input  logic                  rempty,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  rinc,
  input  logic                  par_en,
  input  logic                  par_typ,
  input  logic [DIV_WIDTH-1:0]  div_ratio,
  output logic                  tx_out,
  output logic                  busy
);

  localparam int                   BIT_W    = $clog2(DATA_WIDTH + 1);
  localparam logic [BIT_W-1:0]     LAST_BIT = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0]     BIT_ONE  = BIT_W'(1);
  localparam logic [DIV_WIDTH-1:0] DIV_ONE  = DIV_WIDTH'(1);
  localparam logic [DIV_WIDTH-1:0] DIV_ZERO = {DIV_WIDTH{1'b0}};

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                state_r, state_s;
  logic [DATA_WIDTH-1:0] shift_r, shift_s;
  logic [DIV_WIDTH-1:0]  cyc_r, cyc_s;
  logic [DIV_WIDTH-1:0]  n_r, n_s;
  logic [BIT_W-1:0]      bit_r, bit_s;
  logic                  par_en_r, par_en_s;
  logic                  par_bit_r, par_bit_s;
  logic                  tx_r, tx_s;
  logic                  busy_r, busy_s;
  logic                  last_cyc_s;
  logic                  pop_s;

  function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

  // n_r is at least 1 whenever a frame is active, so n_r-1 never wraps there.
  assign last_cyc_s = (cyc_r == (n_r - DIV_ONE));

  // Pop strobe: held off during reset and whenever the FIFO is empty.
  always_comb begin
    pop_s = 1'b0;
    if (rrst_n && !rempty && ((state_r == IDLE) || ((state_r == STOP) && last_cyc_s))) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
  end

  assign rinc   = pop_s;
  assign tx_out = tx_r;
  assign busy   = busy_r;

  // Next-state, datapath and registered-output values.
  always_comb begin
    state_s   = state_r;
    shift_s   = shift_r;
    cyc_s     = cyc_r;
    n_s       = n_r;
    bit_s     = bit_r;
    par_en_s  = par_en_r;
    par_bit_s = par_bit_r;
    tx_s      = 1'b1;
    busy_s    = 1'b0;
    if (pop_s) begin
      state_s   = START;
      shift_s   = rdata;
      n_s       = (div_ratio == DIV_ZERO) ? DIV_ONE : div_ratio;
      par_en_s  = par_en;
      par_bit_s = calc_parity(rdata, par_typ);
      cyc_s     = DIV_ZERO;
      bit_s     = {BIT_W{1'b0}};
    end else if (state_r == IDLE) begin
      state_s = IDLE;
    end else if (!last_cyc_s) begin
      cyc_s = cyc_r + DIV_ONE;
    end else begin
      cyc_s = DIV_ZERO;
      case (state_r)
        START:   state_s = DATA;
        DATA: begin
          shift_s = {1'b0, shift_r[DATA_WIDTH-1:1]};
          bit_s   = bit_r + BIT_ONE;
          if (bit_r == LAST_BIT) begin
            state_s = par_en_r ? PARITY : STOP;
          end else begin
            state_s = DATA;
          end
        end
        PARITY:  state_s = STOP;
        STOP:    state_s = IDLE;
        default: state_s = IDLE;
      endcase
    end
    // Outputs are registered, so they are derived from the state being entered.
    case (state_s)
      START:   tx_s = 1'b0;
      DATA:    tx_s = shift_s[0];
      PARITY:  tx_s = par_bit_s;
      default: tx_s = 1'b1;
    endcase
    busy_s = (state_s != IDLE);
  end

  // State, datapath and output registers.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_r   <= IDLE;
      shift_r   <= {DATA_WIDTH{1'b0}};
      cyc_r     <= DIV_ZERO;
      n_r       <= DIV_ZERO;
      bit_r     <= {BIT_W{1'b0}};
      par_en_r  <= 1'b0;
      par_bit_r <= 1'b0;
      tx_r      <= 1'b1;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      shift_r   <= shift_s;
      cyc_r     <= cyc_s;
      n_r       <= n_s;
      bit_r     <= bit_s;
      par_en_r  <= par_en_s;
      par_bit_r <= par_bit_s;
      tx_r      <= tx_s;
      busy_r    <= busy_s;
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx_drain.sv
// Self-checking bench for fifo_uart_tx_drain: a FIFO model feeds the DUT and every
// captured per-cycle trace is compared against a frame-level reference model.
module tb_fifo_uart_tx_drain;

  logic       rclk = 1'b0;
  logic       rrst_n;
  logic       rempty;
  logic [7:0] rdata;
  logic       rinc;
  logic       par_en;
  logic       par_typ;
  logic [7:0] div_ratio;
  logic       tx_out;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] mem [0:255];
  logic [7:0] wr_ptr = 8'd0;
  logic [7:0] rd_ptr = 8'd0;

  logic tx_tr [0:1023];
  logic busy_tr [0:1023];
  logic rinc_tr [0:1023];
  logic exp_tx [0:1023];
  logic exp_busy [0:1023];
  logic exp_rinc [0:1023];

  logic [7:0] f_byte [0:7];
  int         f_n [0:7];
  logic       f_pe [0:7];
  logic       f_pt [0:7];

  fifo_uart_tx_drain #(.DATA_WIDTH(8), .DIV_WIDTH(8)) dut (
    .rclk(rclk), .rrst_n(rrst_n), .rempty(rempty), .rdata(rdata), .rinc(rinc),
    .par_en(par_en), .par_typ(par_typ), .div_ratio(div_ratio),
    .tx_out(tx_out), .busy(busy)
  );

  always #5 rclk = ~rclk;

  assign rempty = (wr_ptr == rd_ptr);
  assign rdata  = mem[rd_ptr];
  always @(posedge rclk) if (rinc) rd_ptr <= rd_ptr + 8'd1;

  task automatic push(input logic [7:0] b);
    mem[wr_ptr] = b;
    wr_ptr = wr_ptr + 8'd1;
  endtask

  // Reference: frames listed in f_* play back to back from index 0 (first pop cycle).
  function automatic int build_expected(input int nb);
    int idx;
    idx = 0;
    for (int i = 0; i < 1024; i++) begin
      exp_tx[i] = 1'b1; exp_busy[i] = 1'b0; exp_rinc[i] = 1'b0;
    end
    for (int j = 0; j < nb; j++) begin
      logic bits [0:10];
      int   nbits;
      nbits = f_pe[j] ? 11 : 10;
      bits[0] = 1'b0;
      for (int k = 0; k < 8; k++) bits[k + 1] = f_byte[j][k];
      if (f_pe[j]) bits[9] = (($countones(f_byte[j]) % 2) == 1) ? ~f_pt[j] : f_pt[j];
      bits[nbits - 1] = 1'b1;
      exp_rinc[idx] = 1'b1;
      for (int b = 0; b < nbits; b++)
        for (int c = 0; c < f_n[j]; c++) begin
          exp_tx[idx + 1 + b * f_n[j] + c] = bits[b];
          exp_busy[idx + 1 + b * f_n[j] + c] = 1'b1;
        end
      idx += nbits * f_n[j];
    end
    return idx;
  endfunction

  task automatic capture(input int len);
    for (int i = 0; i < len; i++) begin
      if (i > 0) @(negedge rclk);
      #1;
      tx_tr[i] = tx_out; busy_tr[i] = busy; rinc_tr[i] = rinc;
    end
  endtask

  task automatic test_reset();
    rrst_n = 1'b0;
    repeat (3) @(negedge rclk);
    #1;
    n_cmp++;
    if ({tx_out, busy, rinc} !== 3'b100) begin
      n_err++; $display("FAIL reset_outputs: tx/busy/rinc got %b%b%b want 100", tx_out, busy, rinc);
    end
    @(negedge rclk); rrst_n = 1'b1;
    repeat (3) @(negedge rclk);
    #1;
    n_cmp++;
    if ({tx_out, busy, rinc} !== 3'b100) begin
      n_err++; $display("FAIL idle_after_reset: tx/busy/rinc got %b%b%b want 100", tx_out, busy, rinc);
    end
  endtask

  task automatic test_single();
    int len, first, pulses, bcnt;
    logic [9:0] want;
    want = 10'b1101001010;
    @(negedge rclk);
    div_ratio = 8'd4; par_en = 1'b0; par_typ = 1'b0;
    f_byte[0] = 8'hA5; f_n[0] = 4; f_pe[0] = 1'b0; f_pt[0] = 1'b0;
    len = build_expected(1);
    push(8'hA5);
    capture(len + 4);
    first = -1;
    for (int i = 0; i < len + 4; i++)
      if (first < 0 && {tx_tr[i], busy_tr[i], rinc_tr[i]} !== {exp_tx[i], exp_busy[i], exp_rinc[i]}) first = i;
    n_cmp++;
    if (first >= 0) begin
      n_err++; $display("FAIL single_trace: cycle %0d tx/busy/rinc got %b%b%b want %b%b%b", first,
        tx_tr[first], busy_tr[first], rinc_tr[first], exp_tx[first], exp_busy[first], exp_rinc[first]);
    end
    pulses = 0; bcnt = 0;
    for (int i = 0; i < len + 4; i++) begin
      pulses += int'(rinc_tr[i]); bcnt += int'(busy_tr[i]);
    end
    n_cmp++;
    if (pulses != 1) begin n_err++; $display("FAIL single_rinc_count: got %0d want 1", pulses); end
    n_cmp++;
    if (bcnt != 40) begin n_err++; $display("FAIL single_busy_len: got %0d want 40", bcnt); end
    for (int b = 0; b < 10; b++) begin
      n_cmp++;
      if (tx_tr[1 + 4 * b + 2] !== want[b]) begin
        n_err++; $display("FAIL single_bit%0d: got %b want %b", b, tx_tr[1 + 4 * b + 2], want[b]);
      end
    end
  endtask

  task automatic test_parity();
    int len, first, bcnt;
    for (int pt = 0; pt < 2; pt++) begin
      @(negedge rclk);
      div_ratio = 8'd2; par_en = 1'b1; par_typ = pt[0];
      f_byte[0] = 8'h07; f_n[0] = 2; f_pe[0] = 1'b1; f_pt[0] = pt[0];
      len = build_expected(1);
      push(8'h07);
      capture(len + 4);
      first = -1;
      for (int i = 0; i < len + 4; i++)
        if (first < 0 && {tx_tr[i], busy_tr[i], rinc_tr[i]} !== {exp_tx[i], exp_busy[i], exp_rinc[i]}) first = i;
      n_cmp++;
      if (first >= 0) begin
        n_err++; $display("FAIL parity%0d_trace: cycle %0d tx/busy/rinc got %b%b%b want %b%b%b", pt, first,
          tx_tr[first], busy_tr[first], rinc_tr[first], exp_tx[first], exp_busy[first], exp_rinc[first]);
      end
      n_cmp++;
      if (tx_tr[19] !== ~pt[0]) begin
        n_err++; $display("FAIL parity%0d_bit: got %b want %b", pt, tx_tr[19], ~pt[0]);
      end
      bcnt = 0;
      for (int i = 0; i < len + 4; i++) bcnt += int'(busy_tr[i]);
      n_cmp++;
      if (bcnt != 22) begin n_err++; $display("FAIL parity%0d_len: got %0d want 22", pt, bcnt); end
    end
  endtask

  task automatic test_back_to_back();
    int len, first, pulses, last_pulse, bad_gap;
    logic [7:0] bytes [0:2];
    bytes[0] = 8'h55; bytes[1] = 8'hAA; bytes[2] = 8'hFF;
    @(negedge rclk);
    div_ratio = 8'd1; par_en = 1'b0; par_typ = 1'b0;
    for (int j = 0; j < 3; j++) begin
      f_byte[j] = bytes[j]; f_n[j] = 1; f_pe[j] = 1'b0; f_pt[j] = 1'b0;
    end
    len = build_expected(3);
    for (int j = 0; j < 3; j++) push(bytes[j]);
    capture(len + 4);
    first = -1;
    for (int i = 0; i < len + 4; i++)
      if (first < 0 && {tx_tr[i], busy_tr[i], rinc_tr[i]} !== {exp_tx[i], exp_busy[i], exp_rinc[i]}) first = i;
    n_cmp++;
    if (first >= 0) begin
      n_err++; $display("FAIL b2b_trace: cycle %0d tx/busy/rinc got %b%b%b want %b%b%b", first,
        tx_tr[first], busy_tr[first], rinc_tr[first], exp_tx[first], exp_busy[first], exp_rinc[first]);
    end
    pulses = 0; last_pulse = -1; bad_gap = 0;
    for (int i = 0; i < len + 4; i++)
      if (rinc_tr[i]) begin
        if (last_pulse >= 0 && (i - last_pulse) != 10) bad_gap = i;
        last_pulse = i; pulses++;
      end
    n_cmp++;
    if (pulses != 3 || bad_gap != 0) begin
      n_err++; $display("FAIL b2b_rinc: got %0d pulses (bad spacing at %0d) want 3 spaced 10", pulses, bad_gap);
    end
    first = -1;
    for (int i = 1; i <= 30; i++) if (first < 0 && busy_tr[i] !== 1'b1) first = i;
    n_cmp++;
    if (first >= 0 || busy_tr[31] !== 1'b0) begin
      n_err++; $display("FAIL b2b_busy: busy dropped at %0d or end busy=%b, want 30 high cycles", first, busy_tr[31]);
    end
  endtask

  task automatic test_div_zero();
    int len, first;
    logic [7:0] b;
    b = 8'($urandom);
    @(negedge rclk);
    div_ratio = 8'd0; par_en = 1'b1; par_typ = 1'b1;
    f_byte[0] = b; f_n[0] = 1; f_pe[0] = 1'b1; f_pt[0] = 1'b1;
    len = build_expected(1);
    push(b);
    capture(len + 4);
    first = -1;
    for (int i = 0; i < len + 4; i++)
      if (first < 0 && {tx_tr[i], busy_tr[i], rinc_tr[i]} !== {exp_tx[i], exp_busy[i], exp_rinc[i]}) first = i;
    n_cmp++;
    if (first >= 0) begin
      n_err++; $display("FAIL div_zero: byte %h cycle %0d tx/busy/rinc got %b%b%b want %b%b%b", b, first,
        tx_tr[first], busy_tr[first], rinc_tr[first], exp_tx[first], exp_busy[first], exp_rinc[first]);
    end
  endtask

  task automatic test_div_change();
    int len, first;
    logic [7:0] b;
    b = 8'($urandom);
    @(negedge rclk);
    div_ratio = 8'd3; par_en = 1'b0; par_typ = 1'b0;
    f_byte[0] = b; f_n[0] = 3; f_pe[0] = 1'b0; f_pt[0] = 1'b0;
    len = build_expected(1);
    push(b);
    fork
      capture(len + 4);
      begin
        repeat (10) @(negedge rclk);
        #2 div_ratio = 8'd8; par_en = 1'b1;
      end
    join
    first = -1;
    for (int i = 0; i < len + 4; i++)
      if (first < 0 && {tx_tr[i], busy_tr[i], rinc_tr[i]} !== {exp_tx[i], exp_busy[i], exp_rinc[i]}) first = i;
    n_cmp++;
    if (first >= 0) begin
      n_err++; $display("FAIL div_change: byte %h cycle %0d tx/busy/rinc got %b%b%b want %b%b%b", b, first,
        tx_tr[first], busy_tr[first], rinc_tr[first], exp_tx[first], exp_busy[first], exp_rinc[first]);
    end
  endtask

  task automatic test_random();
    int len, first, nb, m, l0;
    logic [7:0] d_old, d_new;
    logic pe_old, pt_old, pe_new, pt_new;
    for (int it = 0; it < 8; it++) begin
      nb = int'($urandom_range(1, 3));
      d_old = 8'($urandom_range(0, 5)); pe_old = 1'($urandom); pt_old = 1'($urandom);
      d_new = 8'($urandom_range(0, 5)); pe_new = 1'($urandom); pt_new = 1'($urandom);
      for (int j = 0; j < nb; j++) begin
        f_byte[j] = 8'($urandom);
        f_n[j]  = (j == 0) ? ((d_old == 8'd0) ? 1 : int'(d_old)) : ((d_new == 8'd0) ? 1 : int'(d_new));
        f_pe[j] = (j == 0) ? pe_old : pe_new;
        f_pt[j] = (j == 0) ? pt_old : pt_new;
      end
      l0 = (pe_old ? 11 : 10) * f_n[0];
      m = int'($urandom_range(1, l0));
      len = build_expected(nb);
      @(negedge rclk);
      div_ratio = d_old; par_en = pe_old; par_typ = pt_old;
      for (int j = 0; j < nb; j++) push(f_byte[j]);
      fork
        capture(len + 4);
        begin
          repeat (m) @(negedge rclk);
          #2 div_ratio = d_new; par_en = pe_new; par_typ = pt_new;
        end
      join
      first = -1;
      for (int i = 0; i < len + 4; i++)
        if (first < 0 && {tx_tr[i], busy_tr[i], rinc_tr[i]} !== {exp_tx[i], exp_busy[i], exp_rinc[i]}) first = i;
      n_cmp++;
      if (first >= 0) begin
        n_err++; $display("FAIL random%0d: nb=%0d cycle %0d tx/busy/rinc got %b%b%b want %b%b%b", it, nb, first,
          tx_tr[first], busy_tr[first], rinc_tr[first], exp_tx[first], exp_busy[first], exp_rinc[first]);
      end
    end
  endtask

  task automatic test_reset_midframe();
    int len, first, bad;
    logic [7:0] b0, b1;
    b0 = 8'($urandom); b1 = 8'($urandom);
    @(negedge rclk);
    div_ratio = 8'd2; par_en = 1'b0; par_typ = 1'b0;
    push(b0); push(b1);
    repeat (9) @(negedge rclk);
    #1;
    n_cmp++;
    if (tx_out !== b0[3] || busy !== 1'b1) begin
      n_err++; $display("FAIL midframe_pre: tx/busy got %b%b want %b1", tx_out, busy, b0[3]);
    end
    #1 rrst_n = 1'b0;
    #1;
    n_cmp++;
    if ({tx_out, busy, rinc} !== 3'b100) begin
      n_err++; $display("FAIL midframe_reset: tx/busy/rinc got %b%b%b want 100", tx_out, busy, rinc);
    end
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge rclk); #1;
      if ({tx_out, busy, rinc} !== 3'b100) bad++;
    end
    n_cmp++;
    if (bad != 0) begin n_err++; $display("FAIL midframe_hold: got %0d bad cycles want 0", bad); end
    f_byte[0] = b1; f_n[0] = 2; f_pe[0] = 1'b0; f_pt[0] = 1'b0;
    len = build_expected(1);
    @(negedge rclk);
    rrst_n = 1'b1;
    capture(len + 4);
    first = -1;
    for (int i = 0; i < len + 4; i++)
      if (first < 0 && {tx_tr[i], busy_tr[i], rinc_tr[i]} !== {exp_tx[i], exp_busy[i], exp_rinc[i]}) first = i;
    n_cmp++;
    if (first >= 0) begin
      n_err++; $display("FAIL midframe_restart: cycle %0d tx/busy/rinc got %b%b%b want %b%b%b", first,
        tx_tr[first], busy_tr[first], rinc_tr[first], exp_tx[first], exp_busy[first], exp_rinc[first]);
    end
  endtask

  task automatic test_empty_guard();
    int bad_rinc, bad_tx;
    bad_rinc = 0; bad_tx = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge rclk); #1;
      if (rinc !== 1'b0) bad_rinc++;
      if (tx_out !== 1'b1 || busy !== 1'b0) bad_tx++;
    end
    n_cmp++;
    if (bad_rinc != 0) begin n_err++; $display("FAIL empty_rinc: got %0d pulses want 0", bad_rinc); end
    n_cmp++;
    if (bad_tx != 0) begin n_err++; $display("FAIL empty_line: got %0d non-idle cycles want 0", bad_tx); end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rrst_n = 1'b0; par_en = 1'b0; par_typ = 1'b0; div_ratio = 8'd1;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    test_reset();
    test_empty_guard();
    test_single();
    test_parity();
    test_back_to_back();
    test_div_zero();
    test_div_change();
    test_random();
    test_reset_midframe();
    test_empty_guard();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
